// File: rtl/efpga_mae_core.sv
// efpga_mae_core -- eFPGA multiply-add-accumulate (MAE) hard tile.
//
// A single parameterised datapath covers every MAE primitive variant
// (mult, mult_addc, macc and their regi/rego/regio/pipe forms):
//   [C reg] -> stage I (a,b,c,acc_clr,valid) -> multiplier -> stage M -> post-adder -> stage P
// Each stage register can be bypassed through a parameter.
// Latency is IN_REG + MULT_HAS_REG + P_REG.
//
// Parameters
//   IN_REG            register a/b/c/acc_clr/in_valid before the multiplier
//   MULT_HAS_REG      register the product (and its side-band) after the multiplier
//   P_REG             register p/out_valid
//   C_REG             one extra register on c only (caller pre-skews c by a cycle)
//   POST_ADDER_STATIC enable the post-adder; 0 gives p = product
//   USE_FEEDBACK      post-adder operand is p (accumulate) instead of c
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high clear of every register
//   ce           global clock enable, freezes every register including valids
//   in_valid     a/b/c carry a sample; acc_clr marks the start of an accumulation
//   a, b         18-bit signed operands
//   c            40-bit signed addend
//   p            40-bit signed result (wraps modulo 2^40)
//   out_valid    p holds the result of a valid sample

module efpga_mae_core #(
  parameter bit IN_REG            = 1'b0,
  parameter bit MULT_HAS_REG      = 1'b0,
  parameter bit P_REG             = 1'b0,
  parameter bit C_REG             = 1'b0,
  parameter bit POST_ADDER_STATIC = 1'b0,
  parameter bit USE_FEEDBACK      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        in_valid,
  input  logic        acc_clr,
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic [39:0] c,
  output logic [39:0] p,
  output logic        out_valid
);

  // The accumulator lives in stage P and adds into the post-adder,
  // so both must exist for feedback.
  if (USE_FEEDBACK && (!P_REG || !POST_ADDER_STATIC)) begin : g_cfg_err
    $error("efpga_mae_core: USE_FEEDBACK=1 requires P_REG=1 and POST_ADDER_STATIC=1");
  end

  // Sample before the multiplier
  typedef struct packed {
    logic        vld;
    logic        clr;
    logic [17:0] a;
    logic [17:0] b;
    logic [39:0] c;
  } ab_t;

  // Sample after the multiplier
  typedef struct packed {
    logic        vld;
    logic        clr;
    logic [39:0] prod;
    logic [39:0] c;
  } pr_t;

  logic [39:0]        c_q, c_in;
  ab_t                s_in, s_i_q, s_i;
  pr_t                s_m_d, s_m_q, s_m;
  logic signed [35:0] prod36;
  logic [39:0]        addend, sum, p_q;
  logic               ov_q;

  assign c_in = C_REG ? c_q : c;
  assign s_in = '{vld: in_valid, clr: acc_clr, a: a, b: b, c: c_in};
  assign s_i  = IN_REG ? s_i_q : s_in;

  assign prod36 = $signed(s_i.a) * $signed(s_i.b);
  assign s_m_d  = '{vld: s_i.vld, clr: s_i.clr, prod: {{4{prod36[35]}}, prod36}, c: s_i.c};
  assign s_m    = MULT_HAS_REG ? s_m_q : s_m_d;

  // Every register is instantiated; bypassed ones are left unread by the muxes
  // above and trimmed by synthesis.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q   <= '0;
      s_i_q <= '0;
      s_m_q <= '0;
    end else if (ce) begin
      c_q   <= c;
      s_i_q <= s_in;
      s_m_q <= s_m_d;
    end
  end

  // acc_clr zeroes the feedback operand, so a cleared sample loads the product.
  always_comb begin
    addend = '0;
    if (POST_ADDER_STATIC) begin
      if (USE_FEEDBACK) addend = s_m.clr ? '0 : p_q;
      else              addend = s_m.c;
    end
    sum = s_m.prod + addend;
  end

  // In feedback mode a bubble must not disturb the accumulator. Otherwise data
  // flows through regardless of valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q  <= '0;
      ov_q <= 1'b0;
    end else if (ce) begin
      if (!USE_FEEDBACK || s_m.vld) p_q <= sum;
      ov_q <= s_m.vld;
    end
  end

  assign p         = P_REG ? p_q  : sum;
  assign out_valid = P_REG ? ov_q : s_m.vld;

endmodule

// File: tb/tb_efpga_mae_core.sv
// Scoreboard bench for efpga_mae_core. Four builds share one stimulus stream:
//   u0: IN_REG + P_REG, post-adder with c         (L=2)
//   u1: fully combinational, post-adder with c    (L=0)
//   u2: MULT_HAS_REG + P_REG accumulator, C_REG=1 (L=2, c must be ignored)
//   u3: MULT_HAS_REG + P_REG + C_REG, post-adder  (L=2, c taken one cycle early)
// The driver computes expected results from the arithmetic rules and queues them.
// The monitor pops and compares whenever a build presents a result.
module tb_efpga_mae_core;
  logic        clk = 1'b0;
  logic        reset, ce, in_valid, acc_clr;
  logic [17:0] a, b;
  logic [39:0] c;
  logic [39:0] pr [3];
  logic        ovr [3];
  logic [39:0] p1;
  logic        ov1;

  always #5 clk = ~clk;

  efpga_mae_core #(.IN_REG(1), .MULT_HAS_REG(0), .P_REG(1), .C_REG(0), .POST_ADDER_STATIC(1), .USE_FEEDBACK(0))
    u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .p(pr[0]), .out_valid(ovr[0]));
  efpga_mae_core #(.IN_REG(0), .MULT_HAS_REG(0), .P_REG(0), .C_REG(0), .POST_ADDER_STATIC(1), .USE_FEEDBACK(0))
    u1 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .p(p1), .out_valid(ov1));
  efpga_mae_core #(.IN_REG(0), .MULT_HAS_REG(1), .P_REG(1), .C_REG(1), .POST_ADDER_STATIC(1), .USE_FEEDBACK(1))
    u2 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .p(pr[1]), .out_valid(ovr[1]));
  efpga_mae_core #(.IN_REG(0), .MULT_HAS_REG(1), .P_REG(1), .C_REG(1), .POST_ADDER_STATIC(1), .USE_FEEDBACK(0))
    u3 (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .a(a), .b(b), .c(c), .p(pr[2]), .out_valid(ovr[2]));

  typedef struct {
    int          due;  // effective-edge count after which the result is visible
    logic [39:0] p;
  } exp_t;

  exp_t        sbq [3][$];
  logic [39:0] q1 [$];
  int          n_vec = 0, n_bad = 0;
  int          eff_cnt = 0;
  bit          rst_edge = 1'b1, eff_edge = 1'b0;
  logic [39:0] last_p [3];
  bit          last_ov [3];
  logic [39:0] acc, prev_c;
  string       nm [3] = '{"pipe_ip", "accum", "c_reg"};

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-precision signed product, then modulo 2^40.
  function automatic logic [39:0] mul40(input logic [17:0] x, input logic [17:0] y);
    longint r;
    r = longint'($signed(x)) * longint'($signed(y));
    return 40'(r);
  endfunction

  // Edge bookkeeping: effective edges advance the pipes, and reset discards everything in flight.
  always @(posedge clk) begin
    rst_edge <= reset;
    eff_edge <= ce && !reset;
    if (reset) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else if (ce) begin
      eff_cnt <= eff_cnt + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_edge) begin
        chk({nm[i], "_rst_p"}, pr[i], '0);
        chk({nm[i], "_rst_ov"}, 40'(ovr[i]), '0);
        last_p[i]  = '0;
        last_ov[i] = 1'b0;
      end else if (eff_edge) begin
        if (sbq[i].size() > 0 && sbq[i][0].due == eff_cnt) begin
          e = sbq[i].pop_front();
          chk({nm[i], "_ov"}, 40'(ovr[i]), 40'd1);
          chk({nm[i], "_p"}, pr[i], e.p);
          last_p[i]  = e.p;
          last_ov[i] = 1'b1;
        end else begin
          chk({nm[i], "_bubble_ov"}, 40'(ovr[i]), '0);
          if (i == 1) chk({nm[i], "_hold_p"}, pr[i], last_p[i]);
          last_ov[i] = 1'b0;
        end
      end else begin
        chk({nm[i], "_frz_ov"}, 40'(ovr[i]), 40'(last_ov[i]));
        if (last_ov[i] || i == 1) chk({nm[i], "_frz_p"}, pr[i], last_p[i]);
      end
    end
    chk("comb_ov", 40'(ov1), 40'(in_valid));
    if (in_valid) begin
      if (q1.size() > 0) chk("comb_p", p1, q1.pop_front());
      else chk("comb_underflow", 40'(q1.size()), 40'd1);
    end
  end

  // One cycle of stimulus, plus the expected results it implies.
  task automatic drive(input bit rst, input bit cei, input bit v, input bit clr,
                       input logic [17:0] ai, input logic [17:0] bi, input logic [39:0] ci);
    logic [39:0] prod;
    @(posedge clk);
    #1;
    reset = rst; ce = cei; in_valid = v; acc_clr = clr; a = ai; b = bi; c = ci;
    prod = mul40(ai, bi);
    if (v) q1.push_back(prod + ci);
    if (rst) begin
      acc    = '0;
      prev_c = '0;
    end else if (cei) begin
      if (v) begin
        acc = clr ? prod : acc + prod;
        sbq[0].push_back(exp_t'{eff_cnt + 2, prod + ci});
        sbq[1].push_back(exp_t'{eff_cnt + 2, acc});
        sbq[2].push_back(exp_t'{eff_cnt + 2, prod + prev_c});
      end
      prev_c = ci;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; c = '0; acc = '0; prev_c = '0;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);

    // 3 * -4 -> 0xFFFFFFFFF4 two cycles later
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'd3, 18'h3FFFC, 40'd0);
    idle(3);
    // -1 * -1 + 5 = 6 combinationally
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 40'd5);
    idle(3);
    // accumulate (2,3,clr),(4,5),bubble,(1,1) -> 6, 26, hold 26, 27
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'd2, 18'd3, 40'd11);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 18'd4, 18'd5, 40'd22);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 18'd9, 18'd9, 40'd33);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 18'd1, 18'd1, 40'd44);
    idle(3);
    // wrap: load -1, add 2^34 32 times -> 0x7FFFFFFFFF, then +1 -> 0x8000000000
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'd1, 18'h3FFFF, 40'd0);
    for (int k = 0; k < 32; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 18'h20000, 18'h20000, 40'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 18'd1, 18'd1, 40'd0);
    idle(3);
    // three frozen cycles inside a valid stream
    for (int k = 0; k < 5; k++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, 18'($urandom), 18'($urandom), {8'($urandom), 32'($urandom)});
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 1'b1, 1'b0, 18'($urandom), 18'($urandom), {8'($urandom), 32'($urandom)});
    for (int k = 0; k < 5; k++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, 18'($urandom), 18'($urandom), {8'($urandom), 32'($urandom)});
    idle(3);
    // reset mid-accumulation (with a colliding valid), then 2*2 without clr -> 4
    drive(1'b0, 1'b1, 1'b1, 1'b1, 18'd7, 18'd7, 40'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 18'd3, 18'd3, 40'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 18'd5, 18'd5, 40'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 18'd2, 18'd2, 40'd4);
    idle(3);

    // random traffic
    for (int k = 0; k < 800; k++)
      drive($urandom_range(99) < 3, $urandom_range(99) < 85, $urandom_range(99) < 70,
            $urandom_range(99) < 20, 18'($urandom), 18'($urandom),
            {8'($urandom), 32'($urandom)});
    idle(5);

    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk({nm[i], "_leftover"}, 40'(sbq[i].size()), '0);
    chk("comb_leftover", 40'(q1.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
